estirador_pulso: RTL and testbench
==================================

Name: estirador_pulso

Overview:
- Converts single-cycle event pulses (e.g. from the button debouncer) into clean, fixed-width output strobes with a guaranteed low gap between them.
- Sits between the debounced-event domain and slow consumers (LEDs, external strobes, peripheral enables).
- Events arriving while a strobe is in progress are queued in a saturating pending counter, so no event is lost up to the queue depth.

Parameters:
- HOLD_CYCLES, 8, strobe high time in CLK cycles; legal range >=1.
- GAP_CYCLES, 4, minimum low time between strobes in CLK cycles; legal range >=1.
- PEND_W, 3, pending-counter width; max queued events = 2^PEND_W-1.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- entra  input  1  event pulse; every cycle sampled high at a CLK edge counts as one event.
- salida  output  1  stretched strobe, registered.
- ocupado  output  1  high when state is not IDLE or the pending count is nonzero; registered.
- pendientes  output  PEND_W  current pending-event count.
- desborde  output  1  sticky overflow flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, pendientes=0, salida=0, ocupado=0, desborde=0. Reset asserted mid-strobe drops salida immediately and discards the queue.
- States: IDLE, ACTIVO, PAUSA.
- IDLE:
  - entra=1 at edge k -> ACTIVO; salida=1 after edge k (1-edge latency); counter loads HOLD_CYCLES-1.
  - pendientes is not incremented for this event.
- ACTIVO:
  - salida=1. Counter decrements each edge.
  - When counter=0 at an edge -> PAUSA; salida=0; counter loads GAP_CYCLES-1.
  - salida is therefore high for exactly HOLD_CYCLES edges.
- PAUSA:
  - salida=0. Counter decrements each edge.
  - When counter=0 at an edge: if pendientes>0 (after that edge's increment) -> ACTIVO, pendientes decrements, counter loads HOLD_CYCLES-1; otherwise -> IDLE.
- Queuing: entra=1 while in ACTIVO or PAUSA increments pendientes.
- Simultaneous entra=1 and dequeue on the same edge: net pendientes unchanged, and the transition to ACTIVO still occurs.
- Saturation: entra=1 with pendientes=2^PEND_W-1 and no dequeue on that edge -> the event is dropped, desborde sets to 1, pendientes holds.
- ocupado follows the state and pendientes as registered on the same edge; it falls the edge PAUSA->IDLE occurs.
- Counter width: clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). No wrap: counter only decrements while nonzero.
- Held level: entra held high for N cycles counts as N events. Level-to-pulse conversion is upstream's responsibility.

Optional Feature:
- Macro: PULSO_RETRIGGER_EN.
- Defined: entra=1 while in ACTIVO reloads counter to HOLD_CYCLES-1 and does not increment pendientes, extending the current strobe. entra=1 in PAUSA still queues as normal.
- Undefined: ACTIVO events queue exactly as described in Behaviour.
- Port list is identical in both builds.

Test Plan:
- Single event, defaults: reset released, entra=1 at edge 10 only -> salida=1 after edges 10..17, 0 after edge 18; PAUSA through edge 22; ocupado=0 after edge 22; pendientes stays 0.
- Queued pair: entra=1 at edges 10 and 12 -> pendientes=1 after edge 12; second strobe rises after edge 22, high 8 cycles; pendientes=0 after edge 22; ocupado=0 after edge 34.
- Overflow: entra=1 for 10 consecutive edges from IDLE (edges 10..19) -> pendientes saturates at 7 after edge 17; desborde=1 after edge 18; exactly 8 strobes emitted in total.
- Simultaneous enqueue/dequeue: pendientes=1 and entra=1 on the final PAUSA edge -> transition to ACTIVO, pendientes remains 1.
- Async reset mid-strobe: reset=0 between edges while salida=1 -> salida, ocupado and pendientes go 0 without waiting for a clock edge; desborde clears; first event after release behaves as in the single-event case.
- PULSO_RETRIGGER_EN build: entra=1 at edges 10 and 15 -> salida continuously high after edges 10..22, low after edge 23; pendientes stays 0.

Source files
------------

// File: rtl/estirador_pulso.sv
// Pulse stretcher: turns single-cycle events into HOLD_CYCLES-wide strobes separated by at least GAP_CYCLES low,
// queuing events that arrive during a strobe. Define PULSO_RETRIGGER_EN to let events during a strobe extend it instead.
module estirador_pulso #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int PEND_W      = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              entra,
    output logic              salida,
    output logic              ocupado,
    output logic [PEND_W-1:0] pendientes,
    output logic              desborde
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACTIVO, PAUSA} estado_t;

    estado_t           state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              desb_q, desb_d;
    logic              salida_q, salida_d;
    logic              ocup_q, ocup_d;
    logic              enq, deq, retrig;

`ifdef PULSO_RETRIGGER_EN
    assign retrig = entra && (state_q == ACTIVO);
`else
    assign retrig = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            desb_q   <= 1'b0;
            salida_q <= 1'b0;
            ocup_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            desb_q   <= desb_d;
            salida_q <= salida_d;
            ocup_q   <= ocup_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        pend_d  = pend_q;
        desb_d  = desb_q;
        enq     = 1'b0;
        deq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (entra) begin
                    state_d = ACTIVO;
                    cnt_d   = HOLD_LD;
                end
            end
            ACTIVO: begin
                enq = entra && !retrig;
                if (retrig) begin
                    cnt_d = HOLD_LD;
                end else if (cnt_q == '0) begin
                    state_d = PAUSA;
                    cnt_d   = GAP_LD;
                end
            end
            PAUSA: begin
                enq = entra;
                if (cnt_q == '0) begin
                    // An event on this very edge counts toward the restart decision.
                    if ((pend_q != '0) || entra) begin
                        state_d = ACTIVO;
                        cnt_d   = HOLD_LD;
                        deq     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enq && !deq) begin
            if (pend_q == PEND_MAX) desb_d = 1'b1;
            else                    pend_d = pend_q + 1'b1;
        end else if (deq && !enq) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_comb begin
        salida_d = (state_d == ACTIVO);
        ocup_d   = (state_d != IDLE) || (pend_d != '0);
    end

    assign salida     = salida_q;
    assign ocupado    = ocup_q;
    assign pendientes = pend_q;
    assign desborde   = desb_q;

endmodule

// File: tb/tb_estirador_pulso.sv
// Scoreboard bench for estirador_pulso: a timestamp-based reference model pushes expected outputs per edge,
// a negedge monitor pops and compares. Honours PULSO_RETRIGGER_EN when the build defines it.
module tb_estirador_pulso;

    localparam int H    = 8;
    localparam int G    = 4;
    localparam int PW   = 3;
    localparam int MAXP = (1 << PW) - 1;

    typedef struct {
        int salida;
        int ocupado;
        int pend;
        int desb;
    } exp_t;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          entra = 1'b0;
    logic          salida, ocupado, desborde;
    logic [PW-1:0] pendientes;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rises    = 0;
    logic prev_sal = 1'b0;

    // Reference model: strobe start edge and the edge after which it falls; restart decision at hold_end+G.
    int m_t, m_active, m_start, m_hold_end, m_pend, m_ovf;

    estirador_pulso #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
        .CLK(CLK), .reset(reset), .entra(entra), .salida(salida),
        .ocupado(ocupado), .pendientes(pendientes), .desborde(desborde)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_t = 0; m_active = 0; m_start = 0; m_hold_end = 0; m_pend = 0; m_ovf = 0;
    endtask

    task automatic model_enq(input int e);
        if (e != 0) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
        end
    endtask

    task automatic model_edge(input int e);
        exp_t x;
        m_t++;
        if (m_active == 0) begin
            if (e != 0) begin
                m_active = 1; m_start = m_t; m_hold_end = m_t + H;
            end
        end else if (m_t <= m_hold_end) begin
`ifdef PULSO_RETRIGGER_EN
            if (e != 0) m_hold_end = m_t + H;
`else
            model_enq(e);
`endif
        end else if (m_t < m_hold_end + G) begin
            model_enq(e);
        end else begin
            if (m_pend + e > 0) begin
                m_pend = m_pend + e - 1;
                m_start = m_t; m_hold_end = m_t + H;
            end else begin
                m_active = 0;
            end
        end
        x.salida  = (m_active != 0 && m_t < m_hold_end) ? 1 : 0;
        x.ocupado = (m_active != 0 || m_pend > 0) ? 1 : 0;
        x.pend    = m_pend;
        x.desb    = m_ovf;
        sbq.push_back(x);
    endtask

    task automatic step(input int e);
        entra = (e != 0);
        @(posedge CLK);
        model_edge(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    task automatic reset_now();
        @(negedge CLK);
        #1;
        reset = 1'b0;
        entra = 1'b0;
        #1;
        chk("rst_salida", int'(salida), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pend", int'(pendientes), 0);
        chk("rst_desborde", int'(desborde), 0);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge CLK) begin
        exp_t x;
        if (salida && !prev_sal) rises++;
        prev_sal = salida;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("salida", int'(salida), x.salida);
            chk("ocupado", int'(ocupado), x.ocupado);
            chk("pendientes", int'(pendientes), x.pend);
            chk("desborde", int'(desborde), x.desb);
        end
    end

    initial begin
        int pct;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("init_salida", int'(salida), 0);
        chk("init_ocupado", int'(ocupado), 0);
        chk("init_pend", int'(pendientes), 0);
        chk("init_desborde", int'(desborde), 0);
        @(negedge CLK);
        #1;
        reset = 1'b1;

        // Single event, then queued pair, then enqueue on the final gap edge.
        idle(9); step(1); idle(20);
        step(1); step(0); step(1); idle(30);
        step(1); step(0); step(1); idle(9); step(1); idle(40);
`ifdef PULSO_RETRIGGER_EN
        step(1); idle(4); step(1); idle(20);
`endif

        // Overflow burst: 10 consecutive events give exactly 8 strobes.
        rises = 0;
        for (int i = 0; i < 10; i++) step(1);
        idle(120);
`ifndef PULSO_RETRIGGER_EN
        chk("overflow_strobes", rises, 8);
`endif

        // Async reset mid-strobe with a full queue and overflow set.
        for (int i = 0; i < 10; i++) step(1);
        idle(3);
        reset_now();
        rises = 0;
        step(1); idle(20);
        chk("post_reset_strobes", rises, 1);

        // Randomised traffic with changing event density.
        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(3))
                0:       pct = 3;
                1:       pct = 15;
                2:       pct = 50;
                default: pct = 95;
            endcase
            for (int i = 0; i < 80; i++) step(($urandom_range(99) < pct) ? 1 : 0);
        end
        idle(150);

        @(negedge CLK);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
